multicycle_main_control: RTL and testbench

- Moore FSM main control unit for the multi-cycle MIPS datapath.
- Decodes the 6-bit instruction opcode (IR[31:26]) over several clock cycles.
- Drives every datapath enable and mux select, including the 2-bit ALUOp consumed by the ALU control block (00 add, 01 sub, 10 funct-decode, 11 slt).
- Sits between the instruction register and the datapath; one instruction is in flight at a time.

---
 rtl/mips_ctrl_pkg.sv | 62 ++++++
 rtl/multicycle_main_control_if.sv | 34 +++
 rtl/multicycle_main_control.sv | 130 +++++++++++++
 tb/tb_multicycle_main_control.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, ALUOp, mux selects, FSM states.
package mips_ctrl_pkg;

    localparam int STATE_W_DEF = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_SLT  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REXEC  = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_SLTIEX = 4'd11,
        S_IWB    = 4'd12
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_control_if.sv
// Opcode in, datapath controls out; master is the control FSM, slave is the datapath/IR side.
interface multicycle_main_control_if;
    logic [5:0] Op;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic       RegDst;
    logic       InstrDone;
    logic       IllegalOp;
    logic [3:0] State;

    modport master (
        input  Op,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, InstrDone,
               IllegalOp, State
    );

    modport slave (
        output Op,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, InstrDone,
               IllegalOp, State
    );
endinterface

// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multi-cycle MIPS datapath; 2-5 cycles per instruction.
// Outputs decode from the state register only (IllegalOp also looks at Op in DECODE); rst blanks them.
module multicycle_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    multicycle_main_control_if.master   ctrl
);

    state_t state_q;
    state_t state_d;
    ctrl_t  dec;
    ctrl_t  outs;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        dec     = '0;
        case (state_q)
            S_FETCH: begin
                dec.mem_read  = 1'b1;
                dec.ir_write  = 1'b1;
                dec.pc_write  = 1'b1;
                dec.pc_source = PCSRC_ALU;
                dec.alu_op    = ALUOP_ADD;
                dec.alu_src_b = ALUSRCB_FOUR;
                state_d       = S_DECODE;
            end
            S_DECODE: begin
                dec.alu_src_b = ALUSRCB_IMM_SH;
                dec.alu_op    = ALUOP_ADD;
                case (ctrl.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_SLTI:      state_d = S_SLTIEX;
                    default:      dec.illegal_op = 1'b1;
                endcase
            end
            S_MEMADR: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = ALUSRCB_IMM;
                dec.alu_op    = ALUOP_ADD;
                // Op is re-checked here; a corrupted opcode abandons the access rather than guess.
                if (ctrl.Op == OP_LW)      state_d = S_MEMRD;
                else if (ctrl.Op == OP_SW) state_d = S_MEMWR;
            end
            S_MEMRD: begin
                dec.mem_read = 1'b1;
                dec.i_or_d   = 1'b1;
                state_d      = S_MEMWB;
            end
            S_MEMWB: begin
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.instr_done = 1'b1;
            end
            S_MEMWR: begin
                dec.mem_write  = 1'b1;
                dec.i_or_d     = 1'b1;
                dec.instr_done = 1'b1;
            end
            S_REXEC: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = ALUSRCB_B;
                dec.alu_op    = ALUOP_FUNC;
                state_d       = S_RWB;
            end
            S_RWB: begin
                dec.reg_write  = 1'b1;
                dec.reg_dst    = 1'b1;
                dec.instr_done = 1'b1;
            end
            S_BEQ: begin
                dec.alu_src_a     = 1'b1;
                dec.alu_src_b     = ALUSRCB_B;
                dec.alu_op        = ALUOP_SUB;
                dec.pc_write_cond = 1'b1;
                dec.pc_source     = PCSRC_ALUOUT;
                dec.instr_done    = 1'b1;
            end
            S_JUMP: begin
                dec.pc_write   = 1'b1;
                dec.pc_source  = PCSRC_JUMP;
                dec.instr_done = 1'b1;
            end
            S_ADDIEX, S_SLTIEX: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = ALUSRCB_IMM;
                dec.alu_op    = (state_q == S_SLTIEX) ? ALUOP_SLT : ALUOP_ADD;
                state_d       = S_IWB;
            end
            S_IWB: begin
                dec.reg_write  = 1'b1;
                dec.instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Blanking during reset keeps an aborted instruction from issuing a stray write.
    assign outs = rst ? '0 : dec;

    assign ctrl.PCWrite     = outs.pc_write;
    assign ctrl.PCWriteCond = outs.pc_write_cond;
    assign ctrl.IorD        = outs.i_or_d;
    assign ctrl.MemRead     = outs.mem_read;
    assign ctrl.MemWrite    = outs.mem_write;
    assign ctrl.MemtoReg    = outs.mem_to_reg;
    assign ctrl.IRWrite     = outs.ir_write;
    assign ctrl.PCSource    = outs.pc_source;
    assign ctrl.ALUOp       = outs.alu_op;
    assign ctrl.ALUSrcA     = outs.alu_src_a;
    assign ctrl.ALUSrcB     = outs.alu_src_b;
    assign ctrl.RegWrite    = outs.reg_write;
    assign ctrl.RegDst      = outs.reg_dst;
    assign ctrl.InstrDone   = outs.instr_done;
    assign ctrl.IllegalOp   = outs.illegal_op;
    assign ctrl.State       = rst ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: expected state/output vectors queued per instruction.
module tb_multicycle_main_control;

    typedef struct {
        logic       r;
        logic [5:0] op;
        int         st;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];

    multicycle_main_control_if bus();

    multicycle_main_control #(.STATE_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus.master)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,ALUOp,ALUSrcA,ALUSrcB,RegWrite,RegDst,InstrDone}
    function automatic logic [16:0] model_vec(input int s);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, done;
        logic [1:0] pcs, aop, srcb;
        {pcw, pcwc, iord, mr, mw, m2r, irw, srca, rw, rd, done} = '0;
        pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
        case (s)
            0:  begin mr = 1; irw = 1; pcw = 1; srcb = 2'b01; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; done = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin srca = 1; srcb = 2'b10; aop = 2'b11; end
            12: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, srca, srcb, rw, rd, done};
    endfunction

    task automatic push_seq(input logic [5:0] op, input int n, input logic [23:0] seq, input logic ill_last);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.r = 1'b0; e.op = op; e.st = int'(seq[i*4 +: 4]);
            e.ill = ill_last && (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic push_rst(input logic [5:0] op);
        exp_t e;
        e.r = 1'b1; e.op = op; e.st = 0; e.ill = 1'b0;
        sb.push_back(e);
    endtask

    // Applies the next queued cycle and returns what the DUT shows against what the entry requires.
    task automatic step(output int obs_st, output logic [16:0] obs_vec, output logic obs_ill,
                        output int exp_st, output logic [16:0] exp_vec, output logic exp_ill);
        exp_t e;
        e = sb.pop_front();
        @(negedge clk);
        rst = e.r;
        bus.Op = e.op;
        #2;
        cyc++;
        obs_st  = int'(bus.State);
        obs_vec = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.MemtoReg,
                   bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite,
                   bus.RegDst, bus.InstrDone};
        obs_ill = bus.IllegalOp;
        exp_st  = e.r ? 0 : e.st;
        exp_vec = e.r ? 17'd0 : model_vec(e.st);
        exp_ill = e.ill;
    endtask

    task automatic test_reset();
        int os, es; logic [16:0] ov, ev; logic oi, ei;
        for (int i = 0; i < 3; i++) push_rst(6'b100011);
        push_seq(6'b100011, 5, 24'h043210, 1'b0);
        while (sb.size() > 0) begin
            step(os, ov, oi, es, ev, ei);
            vectors++; if (os !== es) begin miscompares++; $display("FAIL reset_state cyc=%0d got %0d want %0d", cyc, os, es); end
            vectors++; if (ov !== ev) begin miscompares++; $display("FAIL reset_outs cyc=%0d got %h want %h", cyc, ov, ev); end
            vectors++; if (oi !== ei) begin miscompares++; $display("FAIL reset_illegal cyc=%0d got %b want %b", cyc, oi, ei); end
        end
    endtask

    task automatic test_lw();
        int os, es; logic [16:0] ov, ev; logic oi, ei;
        push_seq(6'b100011, 5, 24'h043210, 1'b0);
        while (sb.size() > 0) begin
            step(os, ov, oi, es, ev, ei);
            vectors++; if (os !== es) begin miscompares++; $display("FAIL lw_state cyc=%0d got %0d want %0d", cyc, os, es); end
            vectors++; if (ov !== ev) begin miscompares++; $display("FAIL lw_outs cyc=%0d got %h want %h", cyc, ov, ev); end
            vectors++; if (oi !== ei) begin miscompares++; $display("FAIL lw_illegal cyc=%0d got %b want %b", cyc, oi, ei); end
        end
    endtask

    task automatic test_rtype();
        int os, es; logic [16:0] ov, ev; logic oi, ei;
        push_seq(6'b000000, 4, 24'h007610, 1'b0);
        while (sb.size() > 0) begin
            step(os, ov, oi, es, ev, ei);
            vectors++; if (os !== es) begin miscompares++; $display("FAIL rtype_state cyc=%0d got %0d want %0d", cyc, os, es); end
            vectors++; if (ov !== ev) begin miscompares++; $display("FAIL rtype_outs cyc=%0d got %h want %h", cyc, ov, ev); end
            vectors++; if (oi !== ei) begin miscompares++; $display("FAIL rtype_illegal cyc=%0d got %b want %b", cyc, oi, ei); end
        end
    endtask

    task automatic test_back_to_back_beq_j();
        int os, es; logic [16:0] ov, ev; logic oi, ei;
        push_seq(6'b000100, 3, 24'h000810, 1'b0);
        push_seq(6'b000010, 3, 24'h000910, 1'b0);
        while (sb.size() > 0) begin
            step(os, ov, oi, es, ev, ei);
            vectors++; if (os !== es) begin miscompares++; $display("FAIL beq_j_state cyc=%0d got %0d want %0d", cyc, os, es); end
            vectors++; if (ov !== ev) begin miscompares++; $display("FAIL beq_j_outs cyc=%0d got %h want %h", cyc, ov, ev); end
            vectors++; if (oi !== ei) begin miscompares++; $display("FAIL beq_j_illegal cyc=%0d got %b want %b", cyc, oi, ei); end
        end
    endtask

    task automatic test_immediate();
        int os, es; logic [16:0] ov, ev; logic oi, ei;
        push_seq(6'b001010, 4, 24'h00cb10, 1'b0);
        push_seq(6'b001000, 4, 24'h00ca10, 1'b0);
        while (sb.size() > 0) begin
            step(os, ov, oi, es, ev, ei);
            vectors++; if (os !== es) begin miscompares++; $display("FAIL imm_state cyc=%0d got %0d want %0d", cyc, os, es); end
            vectors++; if (ov !== ev) begin miscompares++; $display("FAIL imm_outs cyc=%0d got %h want %h", cyc, ov, ev); end
            vectors++; if (oi !== ei) begin miscompares++; $display("FAIL imm_illegal cyc=%0d got %b want %b", cyc, oi, ei); end
        end
    endtask

    task automatic test_illegal_and_glitch();
        int os, es; logic [16:0] ov, ev; logic oi, ei;
        push_seq(6'b111111, 2, 24'h000010, 1'b1);
        push_seq(6'b101011, 4, 24'h005210, 1'b0);
        // lw decoded, then Op turns into addi while in MEMADR: must drop back to FETCH.
        push_seq(6'b100011, 2, 24'h000010, 1'b0);
        push_seq(6'b001000, 1, 24'h000002, 1'b0);
        push_seq(6'b000000, 4, 24'h007610, 1'b0);
        while (sb.size() > 0) begin
            step(os, ov, oi, es, ev, ei);
            vectors++; if (os !== es) begin miscompares++; $display("FAIL illegal_state cyc=%0d got %0d want %0d", cyc, os, es); end
            vectors++; if (ov !== ev) begin miscompares++; $display("FAIL illegal_outs cyc=%0d got %h want %h", cyc, ov, ev); end
            vectors++; if (oi !== ei) begin miscompares++; $display("FAIL illegal_flag cyc=%0d got %b want %b", cyc, oi, ei); end
        end
    endtask

    task automatic test_reset_abort();
        int os, es; logic [16:0] ov, ev; logic oi, ei;
        push_seq(6'b100011, 4, 24'h003210, 1'b0);
        push_rst(6'b100011);
        push_seq(6'b100011, 5, 24'h043210, 1'b0);
        while (sb.size() > 0) begin
            step(os, ov, oi, es, ev, ei);
            vectors++; if (os !== es) begin miscompares++; $display("FAIL abort_state cyc=%0d got %0d want %0d", cyc, os, es); end
            vectors++; if (ov !== ev) begin miscompares++; $display("FAIL abort_outs cyc=%0d got %h want %h", cyc, ov, ev); end
            vectors++; if (oi !== ei) begin miscompares++; $display("FAIL abort_illegal cyc=%0d got %b want %b", cyc, oi, ei); end
        end
    endtask

    initial begin
        bus.Op = 6'b100011;
        test_reset();
        test_lw();
        test_rtype();
        test_back_to_back_beq_j();
        test_immediate();
        test_illegal_and_glitch();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
